// File: rtl/hazard_sb_pkg.sv
// Shared constants for the scoreboard hazard unit: default widths,
// Tnew encodings and default MDU latencies.
package hazard_sb_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int RA_W_DEF        = 5;
    localparam int TNEW_W_DEF      = 2;

    // Tnew encodings seen from the E stage
    localparam int TNEW_NOW        = 0;  // lui / jal: result already on the E wd bus
    localparam int TNEW_ALU        = 1;  // ALU result lands on the M wd bus
    localparam int TNEW_LOAD       = 2;  // load data lands on the W wd bus

    // Default MDU busy times
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter width able to hold the longer of the two MDU latencies
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// MDU busy counter: loads the mult/div latency on a start, then counts
// down to zero. Freeze holds the count; reset aborts it.
module md_busy_ctr
    import hazard_sb_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // Load on start, otherwise count down towards zero; freeze holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (start) begin
                cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_sb.sv
// Scoreboard hazard/forwarding unit for the 5-stage pipeline. Keeps a
// shadow copy of destination/Tnew/source fields for E, M and W, forwards
// operands to D, E and M, and raises stall on data or MDU hazards.
module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RA_W        = RA_W_DEF,
    parameter int TNEW_W      = TNEW_W_DEF,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [RA_W-1:0]   D_rs,
    input  logic [RA_W-1:0]   D_rt,
    input  logic [TNEW_W-1:0] D_tuse_rs,
    input  logic [TNEW_W-1:0] D_tuse_rt,
    input  logic [RA_W-1:0]   D_wa,
    input  logic [TNEW_W-1:0] D_tnew,
    input  logic              D_md_start,
    input  logic              D_md_div,
    input  logic              D_md_use,
    input  logic [DATA_W-1:0] D_rs_o,
    input  logic [DATA_W-1:0] D_rt_o,
    input  logic [DATA_W-1:0] E_rs_o,
    input  logic [DATA_W-1:0] E_rt_o,
    input  logic [DATA_W-1:0] M_rt_o,
    input  logic [DATA_W-1:0] E_wd,
    input  logic [DATA_W-1:0] M_wd,
    input  logic [DATA_W-1:0] W_wd,
    output logic [DATA_W-1:0] D_rs_m,
    output logic [DATA_W-1:0] D_rt_m,
    output logic [DATA_W-1:0] E_rs_m,
    output logic [DATA_W-1:0] E_rt_m,
    output logic [DATA_W-1:0] M_rt_m,
    output logic              stall,
    output logic              md_busy
);

    localparam logic [TNEW_W-1:0] TUSE_NONE = {TNEW_W{1'b1}};
    localparam int                CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);

    // Shadow slots
    logic [RA_W-1:0]   e_wa, e_rs, e_rt;
    logic [TNEW_W-1:0] e_tnew;
    logic              e_md_start, e_md_div;
    logic [RA_W-1:0]   m_wa, m_rt;
    logic [TNEW_W-1:0] m_tnew;
    logic [RA_W-1:0]   w_wa;

    logic data_stall, md_stall;

    // Tnew never goes below zero once the result is available
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    // Nearest-younger-slot forwarding; a slot wa of 0 never matches since
    // address 0 is answered first, so callers pass '0 for slots they skip.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [RA_W-1:0]   a,
        input logic [RA_W-1:0]   ewa,
        input logic [RA_W-1:0]   mwa,
        input logic [RA_W-1:0]   wwa,
        input logic [DATA_W-1:0] ewd,
        input logic [DATA_W-1:0] mwd,
        input logic [DATA_W-1:0] wwd,
        input logic [DATA_W-1:0] raw
    );
        if (a == '0)        return '0;
        else if (a == ewa)  return ewd;
        else if (a == mwa)  return mwd;
        else if (a == wwa)  return wwd;
        else                return raw;
    endfunction

    // A used source stalls when the nearest producer in E or M is not ready in time
    function automatic logic src_stall(
        input logic [RA_W-1:0]   s,
        input logic [TNEW_W-1:0] tuse,
        input logic [RA_W-1:0]   ewa,
        input logic [TNEW_W-1:0] etnew,
        input logic [RA_W-1:0]   mwa,
        input logic [TNEW_W-1:0] mtnew
    );
        if (s == '0 || tuse == TUSE_NONE) return 1'b0;
        else if (s == ewa)                return etnew > tuse;
        else if (s == mwa)                return mtnew > tuse;
        else                              return 1'b0;
    endfunction

    // Advance the scoreboard: E takes D (or a bubble on stall), M and W shift
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_wa       <= '0;
            e_rs       <= '0;
            e_rt       <= '0;
            e_tnew     <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_wa       <= '0;
            m_rt       <= '0;
            m_tnew     <= '0;
            w_wa       <= '0;
        end else if (!freeze) begin
            if (stall) begin
                e_wa       <= '0;
                e_rs       <= '0;
                e_rt       <= '0;
                e_tnew     <= '0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_wa       <= D_wa;
                e_rs       <= D_rs;
                e_rt       <= D_rt;
                e_tnew     <= D_tnew;
                e_md_start <= D_md_start;
                e_md_div   <= D_md_div;
            end
            m_wa   <= e_wa;
            m_rt   <= e_rt;
            m_tnew <= sat_dec(e_tnew);
            w_wa   <= m_wa;
        end
    end

    md_busy_ctr #(
        .CNT_W       (CNT_W),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .freeze (freeze),
        .start  (e_md_start),
        .div    (e_md_div),
        .busy   (md_busy)
    );

    // Forwarding muxes and stall decision
    always_comb begin
        D_rs_m = fwd(D_rs, e_wa, m_wa, w_wa, E_wd, M_wd, W_wd, D_rs_o);
        D_rt_m = fwd(D_rt, e_wa, m_wa, w_wa, E_wd, M_wd, W_wd, D_rt_o);
        E_rs_m = fwd(e_rs, '0,   m_wa, w_wa, E_wd, M_wd, W_wd, E_rs_o);
        E_rt_m = fwd(e_rt, '0,   m_wa, w_wa, E_wd, M_wd, W_wd, E_rt_o);
        M_rt_m = fwd(m_rt, '0,   '0,   w_wa, E_wd, M_wd, W_wd, M_rt_o);

        data_stall = src_stall(D_rs, D_tuse_rs, e_wa, e_tnew, m_wa, m_tnew)
                   | src_stall(D_rt, D_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
        md_stall   = (D_md_start | D_md_use) & (md_busy | e_md_start);
        stall      = reset & (data_stall | md_stall);
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: reset, load-use, ALU forwarding, $0,
// MDU stall length, freeze hold and reset mid-operation.
module tb_hazard_sb;
    import hazard_sb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam logic [TW-1:0] UNUSED = 2'b11;

    logic          clk = 1'b0;
    logic          reset, freeze;
    logic [AW-1:0] D_rs, D_rt, D_wa;
    logic [TW-1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic          D_md_start, D_md_div, D_md_use;
    logic [DW-1:0] D_rs_o, D_rt_o, E_rs_o, E_rt_o, M_rt_o, E_wd, M_wd, W_wd;
    logic [DW-1:0] D_rs_m, D_rt_m, E_rs_m, E_rt_m, M_rt_m;
    logic          stall, md_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_cyc;

    hazard_sb #(
        .DATA_W(DW), .RA_W(AW), .TNEW_W(TW), .MULT_CYCLES(5), .DIV_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_wa(D_wa), .D_tnew(D_tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .D_rs_o(D_rs_o), .D_rt_o(D_rt_o), .E_rs_o(E_rs_o), .E_rt_o(E_rt_o),
        .M_rt_o(M_rt_o), .E_wd(E_wd), .M_wd(M_wd), .W_wd(W_wd),
        .D_rs_m(D_rs_m), .D_rt_m(D_rt_m), .E_rs_m(E_rs_m), .E_rt_m(E_rt_m),
        .M_rt_m(M_rt_m), .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic nop();
        D_rs = '0; D_rt = '0; D_tuse_rs = UNUSED; D_tuse_rt = UNUSED;
        D_wa = '0; D_tnew = '0;
        D_md_start = 1'b0; D_md_div = 1'b0; D_md_use = 1'b0;
    endtask

    initial begin
        D_rs_o = 32'hA0A0_0001; D_rt_o = 32'hA0A0_0002;
        E_rs_o = 32'hA0A0_0003; E_rt_o = 32'hA0A0_0004; M_rt_o = 32'hA0A0_0005;
        E_wd   = 32'hE0E0_E0E0; M_wd   = 32'hD0D0_D0D0; W_wd   = 32'h0000_1234;
        freeze = 1'b0;

        // 1. reset with a pending destination and an MDU user in D
        reset = 1'b0;
        nop(); D_wa = 5'd5; D_tnew = 2'(TNEW_LOAD); D_rs = 5'd5; D_tuse_rs = 2'd0; D_md_use = 1'b1;
        tick(); tick();
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_md_busy", {31'b0, md_busy}, 32'd0);
        reset = 1'b1;
        nop(); D_rs = 5'd7; D_tuse_rs = UNUSED;
        #1;
        chk("rst_raw_rs", D_rs_m, D_rs_o);

        // 2. load-use: lw $8 then beq $8
        nop(); D_wa = 5'd8; D_tnew = 2'(TNEW_LOAD);
        tick();
        nop(); D_rs = 5'd8; D_tuse_rs = 2'd0;
        #1;
        chk("lu_stall_1", {31'b0, stall}, 32'd1);
        chk("lu_fwd_e", D_rs_m, E_wd);
        tick();
        chk("lu_stall_2", {31'b0, stall}, 32'd1);
        chk("lu_fwd_m", D_rs_m, M_wd);
        tick();
        chk("lu_stall_3", {31'b0, stall}, 32'd0);
        chk("lu_fwd_w", D_rs_m, 32'h0000_1234);

        // 3. ALU -> ALU: addu $3, then addu $9 <- $3,$3 with tuse 1
        nop(); D_wa = 5'd3; D_tnew = 2'(TNEW_ALU);
        tick();
        nop(); D_rs = 5'd3; D_rt = 5'd3; D_tuse_rs = 2'd1; D_tuse_rt = 2'd1;
        D_wa = 5'd9; D_tnew = 2'(TNEW_ALU);
        #1;
        chk("alu_stall", {31'b0, stall}, 32'd0);
        chk("alu_fwd_d", D_rs_m, E_wd);
        tick();
        nop();
        #1;
        chk("alu_fwd_e_rs", E_rs_m, M_wd);
        chk("alu_fwd_e_rt", E_rt_m, M_wd);
        tick();
        chk("alu_fwd_m_rt", M_rt_m, W_wd);

        // 4. a write to $0 is never a hazard nor a forward source
        nop(); D_wa = 5'd0; D_tnew = 2'(TNEW_LOAD);
        tick();
        E_wd = 32'hFFFF_FFFF;
        nop(); D_tuse_rs = 2'd0; D_tuse_rt = 2'd0;
        #1;
        chk("zero_stall", {31'b0, stall}, 32'd0);
        chk("zero_rs", D_rs_m, 32'd0);
        chk("zero_rt", D_rt_m, 32'd0);
        tick();
        chk("zero_e_rs", E_rs_m, 32'd0);
        E_wd = 32'hE0E0_E0E0;

        // 5. div then mflo: eleven stall cycles
        nop(); D_md_start = 1'b1; D_md_div = 1'b1;
        tick();
        nop(); D_md_use = 1'b1; D_wa = 5'd2; D_tnew = 2'(TNEW_ALU);
        #1;
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall !== 1'b1) break;
            n_cyc++;
            tick();
        end
        chk("div_stall_cycles", n_cyc, 32'd11);
        chk("div_busy_done", {31'b0, md_busy}, 32'd0);
        tick();
        nop();

        // 6a. mult, then freeze three cycles: the count must hold
        D_md_start = 1'b1;
        tick();
        nop();
        tick();
        chk("mult_busy", {31'b0, md_busy}, 32'd1);
        tick();
        freeze = 1'b1;
        D_md_use = 1'b1;
        #1;
        chk("frz_stall_comb", {31'b0, stall}, 32'd1);
        tick(); tick(); tick();
        freeze = 1'b0;
        nop();
        #1;
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (md_busy !== 1'b1) break;
            n_cyc++;
            tick();
        end
        chk("frz_busy_left", n_cyc, 32'd4);

        // 6b. reset during a div with a live producer in E
        nop(); D_md_start = 1'b1; D_md_div = 1'b1;
        tick();
        nop(); D_wa = 5'd8; D_tnew = 2'(TNEW_LOAD);
        tick();
        nop(); D_rs = 5'd8; D_rt = 5'd8; D_tuse_rs = 2'd0; D_tuse_rt = 2'd0;
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'd1);
        chk("pre_rst_fwd", D_rs_m, E_wd);
        chk("pre_rst_busy", {31'b0, md_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_stall_suppr", {31'b0, stall}, 32'd0);
        tick();
        chk("rst_busy_abort", {31'b0, md_busy}, 32'd0);
        chk("rst_raw_rs2", D_rs_m, D_rs_o);
        chk("rst_raw_rt2", D_rt_m, D_rt_o);
        reset = 1'b1;
        nop();
        tick();
        chk("rst_busy_stays", {31'b0, md_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
